mux_scan_sampler: RTL
=====================

Name: mux_scan_sampler

Overview:
Sequencer that sits on both sides of the 4-to-1 multiplexer. It drives the mux select lines, steps through the four input channels, and waits a programmable settle time on each one. It then samples the single-bit mux output and packs the four samples into a 4-bit frame. The frame is handed downstream over a valid/ready handshake.

Parameters:
SETTLE_CYCLES, 2, clock cycles sel is held stable before sampling; legal range 1..15
CONTINUOUS, 0, 1 = start a new scan automatically after each frame handshake; 0 = one scan per start pulse

Ports:
clk  input  1  system clock; all logic is rising-edge triggered
rst_n  input  1  asynchronous active-low reset
start  input  1  request a scan; accepted only in IDLE
enable_mask  input  4  per-channel enable; bit k enables channel k; sampled when start is accepted
sel  output  2  drives mux select s; value k selects channel k
mux_out  input  1  mux output (out)
frame  output  4  frame[k] = sample taken with sel==k; 0 for disabled channels
frame_valid  output  1  frame holds a complete scan
frame_ready  input  1  downstream accepts the frame
busy  output  1  high in every state except IDLE
overrun  output  1  sticky; set when start is high while busy

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: sel=0, frame=0, frame_valid=0, busy=0, overrun=0, state=IDLE, internal mask and shadow register=0.
- Reset asserted mid-scan forces all reset values immediately; no partial frame is ever published.
- FSM states: IDLE, SETTLE, SAMPLE, PUBLISH, HOLD.
- IDLE:
  - start=1 latches enable_mask and clears overrun (the accepted start has priority over overrun set).
  - Goes to SETTLE on the lowest enabled channel, with sel set to that channel.
  - If mask==0, goes directly to PUBLISH.
- SETTLE:
  - sel is held constant and the settle counter is loaded with SETTLE_CYCLES-1.
  - Moves to SAMPLE when the counter reaches 0, i.e. SETTLE_CYCLES cycles in SETTLE.
- SAMPLE (1 cycle):
  - shadow[sel] <= mux_out.
  - If a higher enabled channel exists, sel jumps to it and the FSM returns to SETTLE.
  - Otherwise goes to PUBLISH.
  - Disabled channels are skipped, never visited.
- PUBLISH (1 cycle):
  - frame <= shadow, with disabled bits forced to 0.
  - frame_valid <= 1.
  - Shadow register cleared. Goes to HOLD.
- HOLD:
  - frame and frame_valid are held stable until frame_valid&&frame_ready at a rising edge.
  - On that edge, frame_valid drops the next cycle and frame keeps its value.
  - Next state is IDLE, or SETTLE/PUBLISH with the stored mask if CONTINUOUS=1.
- Latency:
  - N enabled channels: frame_valid rises N*(SETTLE_CYCLES+1)+1 cycles after the edge that accepts start.
  - With mask=4'hF and SETTLE_CYCLES=2, this is 13 cycles.
- sel stays at the last sampled channel through PUBLISH and HOLD. It returns to 0 on entry to IDLE.
- Boundary rules:
  - start during busy, including on the handshake edge, is ignored and sets overrun.
  - After a handshake in one-shot mode there is at least one IDLE cycle before the next start is accepted.
  - enable_mask changes during a scan have no effect.
  - frame_ready while frame_valid=0 is ignored.

Decomposition:
- Package mux_scan_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, PUBLISH, HOLD)
  - NUM_CH=4, SEL_W=2, CNT_W=4
  - a next-enabled-channel function (lowest set bit of mask above the current index)
- Sub-module settle_counter: down-counter with load, value and done outputs, width CNT_W.
- FSM, shadow register and handshake stay in mux_scan_sampler.

Test Plan:
1. Behavioural 4:1 mux model returns input 4'b0100 with all channels enabled, start pulse, frame_ready=1 → sel walks 0,1,2,3 with each value held 3 cycles; frame_valid at cycle 13; frame=4'b0100.
2. enable_mask=4'b1010, inputs 4'b1111 → only sel 1 and 3 visited; frame=4'b1010; frame_valid at cycle 7.
3. enable_mask=0 with start → frame=0 and frame_valid at cycle 1.
4. frame_ready held low 10 cycles, start pulsed during HOLD → frame stable, overrun=1, no new scan; ready=1 → valid drops next cycle; next accepted start clears overrun.
5. rst_n pulled low during a SETTLE on channel 2 → sel=0, busy=0, frame_valid=0 immediately; a fresh start gives a correct full frame.
6. CONTINUOUS=1, inputs changed between frames (4'b0011 then 4'b1100) → back-to-back frames 4'b0011, 4'b1100 with no IDLE gap.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 4:1 mux scan sequencer.
// Holds the FSM state encoding, widths and channel search.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        SAMPLE  = 3'd2,
        PUBLISH = 3'd3,
        HOLD    = 3'd4
    } state_t;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [SEL_W:0] next_ch(
        input logic [NUM_CH-1:0] mask,
        input logic [SEL_W:0]    from
    );
        logic [SEL_W:0] r;
        r = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask[k] && (k >= int'(from)))
                r = {1'b1, k[SEL_W-1:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_sampler_settle_counter.sv
// Settle-time down-counter for the mux scan sequencer.
// Load has priority; decrement saturates at zero.
module settle_counter
    import mux_scan_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign value = cnt;
    assign done  = (cnt == '0);

endmodule

// File: rtl/mux_scan_sampler.sv
// Scans four mux channels, samples each after a settle time,
// and publishes a 4-bit frame over a valid/ready handshake.
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter bit CONTINUOUS    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] enable_mask,
    output logic [SEL_W-1:0]  sel,
    input  logic              mux_out,
    output logic [NUM_CH-1:0] frame,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              busy,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] shadow;
    logic              cnt_load;
    logic              cnt_dec;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_done;
    logic [SEL_W:0]    first_ch;
    logic [SEL_W:0]    again_ch;
    logic [SEL_W:0]    nxt_ch;
    logic              hs;

    assign first_ch = next_ch(enable_mask, '0);
    assign again_ch = next_ch(mask, '0);
    assign nxt_ch   = next_ch(mask, {1'b0, sel} + (SEL_W+1)'(1));
    assign hs       = frame_valid && frame_ready;
    assign busy     = (state != IDLE);
    assign cnt_dec  = (state == SETTLE) && (cnt_val != '0);

    // Reload the settle count on every entry into SETTLE.
    always_comb begin
        cnt_load = 1'b0;
        unique case (state)
            IDLE:    cnt_load = start && first_ch[SEL_W];
            SAMPLE:  cnt_load = nxt_ch[SEL_W];
            HOLD:    cnt_load = hs && CONTINUOUS && again_ch[SEL_W];
            default: cnt_load = 1'b0;
        endcase
    end

    settle_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (SETTLE_LD),
        .dec      (cnt_dec),
        .value    (cnt_val),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= '0;
            mask        <= '0;
            shadow      <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (start && (state != IDLE))
                overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mask    <= enable_mask;
                        overrun <= 1'b0;
                        if (first_ch[SEL_W]) begin
                            sel   <= first_ch[SEL_W-1:0];
                            state <= SETTLE;
                        end else begin
                            state <= PUBLISH;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_done)
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    shadow[sel] <= mux_out;
                    if (nxt_ch[SEL_W]) begin
                        sel   <= nxt_ch[SEL_W-1:0];
                        state <= SETTLE;
                    end else begin
                        state <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    frame       <= shadow & mask;
                    frame_valid <= 1'b1;
                    shadow      <= '0;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (hs) begin
                        frame_valid <= 1'b0;
                        if (CONTINUOUS) begin
                            if (again_ch[SEL_W]) begin
                                sel   <= again_ch[SEL_W-1:0];
                                state <= SETTLE;
                            end else begin
                                state <= PUBLISH;
                            end
                        end else begin
                            sel   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    sel   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
